// File: rtl/find_collector_rd_if.sv
// Read-side handshake between find_collector and the Wishbone register block.
// The collector presents the show-ahead FIFO head and the consumer pops it
// by raising ready while valid is high.
interface find_collector_rd_if #(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 16,
  parameter int UNIT_W    = 2
);
  logic                 valid;
  logic                 ready;
  logic [SEQ_WIDTH-1:0] seq;
  logic [E_WIDTH-1:0]   e;
  logic [UNIT_W-1:0]    unit;

  modport master (output valid, output seq, output e, output unit, input ready);
  modport slave  (input valid, input seq, input e, input unit, output ready);
endinterface

// File: rtl/find_collector.sv
// find_collector: captures each parallel find unit's result exactly once,
// tracks the minimum-energy result, and queues every captured result in a
// show-ahead FIFO drained through the read interface.
module find_collector #(
  parameter int  SEQ_WIDTH      = 8,
  parameter int  E_WIDTH        = 16,
  parameter int  PARALLEL_UNITS = 4,
  parameter int  FIFO_DEPTH     = 4,
  localparam int UNIT_W         = (PARALLEL_UNITS > 1) ? $clog2(PARALLEL_UNITS) : 1,
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_ni,
  input  logic                               i_clear,
  input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] i_seq,
  input  logic [PARALLEL_UNITS*E_WIDTH-1:0]   i_e,
  input  logic [PARALLEL_UNITS-1:0]           i_done,
  output logic                               o_best_valid,
  output logic [SEQ_WIDTH-1:0]               o_best_seq,
  output logic [E_WIDTH-1:0]                 o_best_e,
  output logic [UNIT_W-1:0]                  o_best_unit,
  output logic                               o_all_done,
  output logic [CNT_W-1:0]                   o_fifo_count,
  output logic                               o_overflow,
  find_collector_rd_if.master                rd
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Capture bookkeeping
  logic [PARALLEL_UNITS-1:0] captured_q, captured_d;
  logic [PARALLEL_UNITS-1:0] pending_s;
  logic [PARALLEL_UNITS-1:0] sel_onehot_s;
  logic                      sel_found_s;
  logic [UNIT_W-1:0]         sel_unit_s;
  logic [SEQ_WIDTH-1:0]      sel_seq_s;
  logic [E_WIDTH-1:0]        sel_e_s;

  // Best-result registers
  logic                 best_valid_q, best_valid_d;
  logic [SEQ_WIDTH-1:0] best_seq_q, best_seq_d;
  logic [E_WIDTH-1:0]   best_e_q, best_e_d;
  logic [UNIT_W-1:0]    best_unit_q, best_unit_d;
  logic                 overflow_q, overflow_d;

  // FIFO state
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SEQ_WIDTH-1:0] mem_seq_q  [FIFO_DEPTH];
  logic [SEQ_WIDTH-1:0] mem_seq_d  [FIFO_DEPTH];
  logic [E_WIDTH-1:0]   mem_e_q    [FIFO_DEPTH];
  logic [E_WIDTH-1:0]   mem_e_d    [FIFO_DEPTH];
  logic [UNIT_W-1:0]    mem_unit_q [FIFO_DEPTH];
  logic [UNIT_W-1:0]    mem_unit_d [FIFO_DEPTH];

  logic rd_valid_s;
  logic pop_s;
  logic room_s;
  logic push_s;

  // Pick the lowest-index unit that is done but not yet captured.
  always_comb begin
    pending_s    = i_done & ~captured_q;
    sel_found_s  = 1'b0;
    sel_onehot_s = {PARALLEL_UNITS{1'b0}};
    sel_unit_s   = {UNIT_W{1'b0}};
    sel_seq_s    = {SEQ_WIDTH{1'b0}};
    sel_e_s      = {E_WIDTH{1'b0}};
    // Walk downwards so the lowest pending index is the last one written.
    for (int k = PARALLEL_UNITS - 1; k >= 0; k--) begin
      if (pending_s[k]) begin
        sel_found_s  = 1'b1;
        sel_onehot_s = {PARALLEL_UNITS{1'b0}};
        sel_onehot_s[k] = 1'b1;
        sel_unit_s   = UNIT_W'(k);
        sel_seq_s    = i_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
        sel_e_s      = i_e[k*E_WIDTH +: E_WIDTH];
      end else begin
        sel_found_s  = sel_found_s;
      end
    end
  end

  // FIFO handshake qualifiers: a full FIFO still accepts a push when the head pops.
  always_comb begin
    rd_valid_s = (count_q != {CNT_W{1'b0}});
    pop_s      = rd_valid_s & rd.ready;
    room_s     = (count_q < CNT_W'(FIFO_DEPTH)) | pop_s;
    push_s     = sel_found_s & room_s;
  end

  // Next-state for capture flags, best result, overflow and FIFO; clear wins.
  always_comb begin
    captured_d   = captured_q;
    best_valid_d = best_valid_q;
    best_seq_d   = best_seq_q;
    best_e_d     = best_e_q;
    best_unit_d  = best_unit_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_seq_d    = mem_seq_q;
    mem_e_d      = mem_e_q;
    mem_unit_d   = mem_unit_q;

    if (i_clear) begin
      captured_d   = {PARALLEL_UNITS{1'b0}};
      best_valid_d = 1'b0;
      best_seq_d   = {SEQ_WIDTH{1'b0}};
      best_e_d     = {E_WIDTH{1'b0}};
      best_unit_d  = {UNIT_W{1'b0}};
      overflow_d   = 1'b0;
      wr_ptr_d     = {PTR_W{1'b0}};
      rd_ptr_d     = {PTR_W{1'b0}};
      count_d      = {CNT_W{1'b0}};
    end else begin
      captured_d = captured_q | sel_onehot_s;

      // Strict less-than: on a tie the earlier capture stays best.
      if (sel_found_s && (!best_valid_q || (sel_e_s < best_e_q))) begin
        best_valid_d = 1'b1;
        best_seq_d   = sel_seq_s;
        best_e_d     = sel_e_s;
        best_unit_d  = sel_unit_s;
      end else begin
        best_valid_d = best_valid_q;
      end

      if (push_s) begin
        mem_seq_d[wr_ptr_q]  = sel_seq_s;
        mem_e_d[wr_ptr_q]    = sel_e_s;
        mem_unit_d[wr_ptr_q] = sel_unit_s;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1'b1);
      end else if (sel_found_s) begin
        overflow_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      captured_q   <= {PARALLEL_UNITS{1'b0}};
      best_valid_q <= 1'b0;
      best_seq_q   <= {SEQ_WIDTH{1'b0}};
      best_e_q     <= {E_WIDTH{1'b0}};
      best_unit_q  <= {UNIT_W{1'b0}};
      overflow_q   <= 1'b0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_seq_q[i]  <= {SEQ_WIDTH{1'b0}};
        mem_e_q[i]    <= {E_WIDTH{1'b0}};
        mem_unit_q[i] <= {UNIT_W{1'b0}};
      end
    end else begin
      captured_q   <= captured_d;
      best_valid_q <= best_valid_d;
      best_seq_q   <= best_seq_d;
      best_e_q     <= best_e_d;
      best_unit_q  <= best_unit_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_seq_q    <= mem_seq_d;
      mem_e_q      <= mem_e_d;
      mem_unit_q   <= mem_unit_d;
    end
  end

  // Output mapping; FIFO head data is forced to zero while empty.
  always_comb begin
    o_best_valid = best_valid_q;
    o_best_seq   = best_seq_q;
    o_best_e     = best_e_q;
    o_best_unit  = best_unit_q;
    o_all_done   = &captured_q;
    o_fifo_count = count_q;
    o_overflow   = overflow_q;
    rd.valid     = rd_valid_s;
    if (rd_valid_s) begin
      rd.seq  = mem_seq_q[rd_ptr_q];
      rd.e    = mem_e_q[rd_ptr_q];
      rd.unit = mem_unit_q[rd_ptr_q];
    end else begin
      rd.seq  = {SEQ_WIDTH{1'b0}};
      rd.e    = {E_WIDTH{1'b0}};
      rd.unit = {UNIT_W{1'b0}};
    end
  end

endmodule
